// File: rtl/r16_out_reader_if.sv
// -----------------------------------------------------------------------------
// r16_out_reader_if
// Groups the reader's two buses:
//   - bank read port   : rd_en, rd_bn, rd_ma (reader -> banks),
//                        rdata_b0, rdata_b1 (banks -> reader)
//   - output stream    : out_data, out_idx, out_valid (reader -> sink),
//                        out_ready (sink -> reader)
// master = the reader itself, slave = the bank/sink environment.
// -----------------------------------------------------------------------------
interface r16_out_reader_if #(
   parameter int A_WIDTH  = 11,
   parameter int BC_WIDTH = 12,
   parameter int W_WIDTH  = 1024
);
   logic                rd_en;
   logic                rd_bn;
   logic [A_WIDTH-1:0]  rd_ma;
   logic [W_WIDTH-1:0]  rdata_b0;
   logic [W_WIDTH-1:0]  rdata_b1;
   logic [W_WIDTH-1:0]  out_data;
   logic [BC_WIDTH-1:0] out_idx;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output rd_en, rd_bn, rd_ma, out_data, out_idx, out_valid,
      input  rdata_b0, rdata_b1, out_ready
   );

   modport slave (
      input  rd_en, rd_bn, rd_ma, out_data, out_idx, out_valid,
      output rdata_b0, rdata_b1, out_ready
   );
endinterface

// File: rtl/r16_out_reader.sv
// -----------------------------------------------------------------------------
// r16_out_reader
// Drains the final-stage result of the radix-16 65536-point FFT from the two
// conflict-free banks in natural output order, one butterfly-group word per k.
// Reads are credit-limited so that every read in flight always has a FIFO slot.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       one-cycle pulse in IDLE begins a drain of 2**BC_WIDTH words
//   busy        high while the drain is running (RUN/DRAIN)
//   done        one-cycle pulse after the last word is accepted
//   bus         read port + output stream (see r16_out_reader_if)
// -----------------------------------------------------------------------------
module r16_out_reader #(
   parameter int A_WIDTH    = 11,
   parameter int BC_WIDTH   = 12,
   parameter int W_WIDTH    = 1024,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   r16_out_reader_if.master bus
);

   localparam int N_DIG = BC_WIDTH / 4;
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 2);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [BC_WIDTH-1:0] K_LAST   = '1;
   localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [BC_WIDTH-1:0] k, bc;
   logic                issue, wr, pop;
   logic [CNT_W-1:0]    inflight, fifo_count;

   logic                rd_en_q, rd_bn_q;
   logic [A_WIDTH-1:0]  rd_ma_q;
   logic [BC_WIDTH-1:0] rd_k_q;

   // Return-path tags: stage RD_LAT-1 lines up with the bank data.
   logic [RD_LAT-1:0]   tag_v, tag_bn;
   logic [BC_WIDTH-1:0] tag_k [RD_LAT];

   logic [W_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
   logic [BC_WIDTH-1:0] fifo_idx  [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Final-stage digit reversal: k = {k2,k1,k0} -> BC = {k0,k1,k2}.
   always_comb begin
      bc = '0;
      for (int d = 0; d < N_DIG; d++) bc[4*d +: 4] = k[4*(N_DIG-1-d) +: 4];
   end

   // Reads issued but not yet written into the FIFO.
   always_comb begin
      inflight = CNT_W'(rd_en_q);
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(tag_v[i]);
   end

   // The count used here is pre-pop, so a pop only frees its credit next cycle.
   assign issue = (state == S_RUN) && ((inflight + fifo_count) < DEPTH_C);
   assign wr    = tag_v[RD_LAT-1];
   assign pop   = bus.out_valid && bus.out_ready;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (issue && (k == K_LAST)) state_nxt = S_DRAIN;
         S_DRAIN: if ((inflight == '0) && (fifo_count == CNT_W'(1)) && pop) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         k       <= '0;
         rd_en_q <= 1'b0;
         rd_bn_q <= 1'b0;
         rd_ma_q <= '0;
         rd_k_q  <= '0;
         tag_v   <= '0;
      end else begin
         state   <= state_nxt;
         rd_en_q <= issue;
         if ((state == S_IDLE) && start) begin
            k <= '0;
         end else if (issue && (k != K_LAST)) begin
            k <= k + 1'b1;
         end
         if (issue) begin
            rd_bn_q <= ^bc;
            rd_ma_q <= bc[BC_WIDTH-1:1];
            rd_k_q  <= k;
         end
         tag_v[0] <= rd_en_q;
         for (int i = 1; i < RD_LAT; i++) tag_v[i] <= tag_v[i-1];
      end
   end

   // NOTE: pure data storage (tag payloads, FIFO words) is not reset; the
   // valid bits and counters that qualify it are, which is all that matters.
   always_ff @(posedge clk) begin
      tag_bn[0] <= rd_bn_q;
      tag_k[0]  <= rd_k_q;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_bn[i] <= tag_bn[i-1];
         tag_k[i]  <= tag_k[i-1];
      end
      if (wr) begin
         fifo_data[wr_ptr] <= tag_bn[RD_LAT-1] ? bus.rdata_b1 : bus.rdata_b0;
         fifo_idx[wr_ptr]  <= tag_k[RD_LAT-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr)  wr_ptr <= next_ptr(wr_ptr);
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         case ({wr, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   assign busy          = (state == S_RUN) || (state == S_DRAIN);
   assign done          = (state == S_DONE);
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_bn     = rd_bn_q;
   assign bus.rd_ma     = rd_ma_q;
   assign bus.out_valid = (fifo_count != '0);
   // Gated to zero when empty so the unreset storage never shows at the port.
   assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
   assign bus.out_idx   = bus.out_valid ? fifo_idx[rd_ptr]  : '0;

endmodule

// File: tb/tb_r16_out_reader.sv
// -----------------------------------------------------------------------------
// tb_r16_out_reader
// Scoreboard bench: each start pushes the full expected natural-order stream
// (index + bank-model word at BC(k)); every cycle with out_valid compares the
// head, and an accept pops it. A bank model returns data RD_LAT cycles after
// rd_en and random noise otherwise, so mistimed captures show up.
// -----------------------------------------------------------------------------
module tb_r16_out_reader;
   localparam int A_WIDTH    = 11;
   localparam int BC_WIDTH   = 12;
   localparam int W_WIDTH    = 1024;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int N_WORDS    = 4096;

   typedef struct {
      logic [BC_WIDTH-1:0] idx;
      logic [W_WIDTH-1:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done;

   exp_t sb[$];
   int   n_vec = 0, n_miscmp = 0;
   int   iss_k = 0, n_acc = 0, done_cnt = 0;

   r16_out_reader_if #(.A_WIDTH(A_WIDTH), .BC_WIDTH(BC_WIDTH), .W_WIDTH(W_WIDTH)) bus ();

   r16_out_reader #(
      .A_WIDTH(A_WIDTH), .BC_WIDTH(BC_WIDTH), .W_WIDTH(W_WIDTH),
      .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W_WIDTH-1:0] bank_word(input logic bn, input logic [A_WIDTH-1:0] ma);
      logic [W_WIDTH-1:0] w;
      for (int i = 0; i < 32; i++) w[i*32 +: 32] = {bn, 5'(i), 15'(i * 97) ^ 15'h2B1D, ma};
      return w;
   endfunction

   function automatic logic [W_WIDTH-1:0] noise();
      logic [W_WIDTH-1:0] w;
      for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [BC_WIDTH-1:0] rev_digits(input logic [BC_WIDTH-1:0] kk);
      return {kk[3:0], kk[7:4], kk[11:8]};
   endfunction

   // Bank model: each bank answers only its own reads, RD_LAT cycles later.
   logic [W_WIDTH-1:0] b0_pipe [RD_LAT];
   logic [W_WIDTH-1:0] b1_pipe [RD_LAT];
   always @(posedge clk) begin
      b0_pipe[0] <= (bus.rd_en && !bus.rd_bn) ? bank_word(1'b0, bus.rd_ma) : noise();
      b1_pipe[0] <= (bus.rd_en &&  bus.rd_bn) ? bank_word(1'b1, bus.rd_ma) : noise();
      for (int i = 1; i < RD_LAT; i++) begin
         b0_pipe[i] <= b0_pipe[i-1];
         b1_pipe[i] <= b1_pipe[i-1];
      end
   end
   assign bus.rdata_b0 = b0_pipe[RD_LAT-1];
   assign bus.rdata_b1 = b1_pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [W_WIDTH-1:0] got, input logic [W_WIDTH-1:0] want);
      int lane;
      n_vec++;
      if (got !== want) begin
         n_miscmp++;
         lane = 0;
         for (int i = 15; i >= 0; i--) if (got[i*64 +: 64] !== want[i*64 +: 64]) lane = i;
         $display("FAIL %s: lane %0d got %h want %h", tag, lane, got[lane*64 +: 64], want[lane*64 +: 64]);
      end
   endtask

   task automatic begin_pass();
      logic [BC_WIDTH-1:0] kk, b;
      exp_t e;
      sb.delete();
      for (int i = 0; i < N_WORDS; i++) begin
         kk     = BC_WIDTH'(i);
         b      = rev_digits(kk);
         e.idx  = kk;
         e.data = bank_word(^b, b[BC_WIDTH-1:1]);
         sb.push_back(e);
      end
      iss_k = 0; n_acc = 0; done_cnt = 0;
   endtask

   // Observes the current cycle; called at the falling edge after inputs are set.
   task automatic monitor();
      logic [BC_WIDTH-1:0] kk, b;
      if (bus.rd_en) begin
         check("rd_in_range", (iss_k < N_WORDS), 1);
         kk = BC_WIDTH'(iss_k);
         b  = rev_digits(kk);
         check("rd_bn", bus.rd_bn, ^b);
         check("rd_ma", bus.rd_ma, b[BC_WIDTH-1:1]);
         if (kk == 12'h001) begin
            check("addr001_bn", bus.rd_bn, 1);
            check("addr001_ma", bus.rd_ma, 11'h080);
         end
         if (kk == 12'h123) begin
            // BC = 0x321 has four set bits, so even parity selects bank 0.
            check("addr123_bn", bus.rd_bn, 0);
            check("addr123_ma", bus.rd_ma, 11'h190);
         end
         if (kk == 12'hFFF) begin
            check("addrfff_bn", bus.rd_bn, 0);
            check("addrfff_ma", bus.rd_ma, 11'h7FF);
         end
         iss_k++;
         check("outstanding_le_depth", ((iss_k - n_acc) <= FIFO_DEPTH), 1);
      end
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            check("sb_size", sb.size(), 1);
         end else begin
            check("out_idx", bus.out_idx, sb[0].idx);
            check("out_data", bus.out_data, sb[0].data);
            if (bus.out_ready) begin
               void'(sb.pop_front());
               n_acc++;
            end
         end
      end
      if (done) begin
         done_cnt++;
         check("done_after_last", n_acc, N_WORDS);
         check("done_busy_low", busy, 0);
      end
   endtask

   task automatic cyc(input logic rdy, input logic st);
      bus.out_ready = rdy;
      start         = st;
      monitor();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_rd_en"}, bus.rd_en, 0);
      check({tag, "_rd_bn"}, bus.rd_bn, 0);
      check({tag, "_rd_ma"}, bus.rd_ma, 0);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_idx"},   bus.out_idx, 0);
      check({tag, "_data"},  bus.out_data, 0);
   endtask

   // mode 0: ready high (+ stray starts), 1: 20-cycle stall, 2: random ready
   task automatic run_pass(input int mode);
      int   guard, hold;
      logic r, st;
      guard = 0; hold = 0;
      while (done_cnt == 0 && guard < 30000) begin
         r = 1'b1; st = 1'b0;
         if (mode == 1 && n_acc >= 1000 && hold < 20) begin
            r = 1'b0;
            if (hold >= 15) begin
               check("bp_no_rd_en", bus.rd_en, 0);
               check("bp_valid_held", bus.out_valid, 1);
            end
            hold++;
         end else if (mode == 2) begin
            r = 1'($urandom_range(0, 1));
         end
         if (mode == 0 && (guard == 300 || guard == 301 || guard == 3000)) st = 1'b1;
         cyc(r, st);
         guard++;
      end
      check("pass_done_once", done_cnt, 1);
      check("pass_words", n_acc, N_WORDS);
      check("pass_sb_empty", sb.size(), 0);
      check("after_done_low", done, 0);
      check("after_busy_low", busy, 0);
   endtask

   task automatic start_pass();
      begin_pass();
      cyc(1'b1, 1'b1);
      check("busy_rise", busy, 1);
   endtask

   initial begin
      int lat, guard;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      cyc(1'b1, 1'b0);
      check("idle_busy", busy, 0);

      // Pass 1: free-running, first-word latency and stray starts.
      start_pass();
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         cyc(1'b1, 1'b0);
         lat++;
      end
      check("first_valid_latency", lat, 5);
      run_pass(0);

      // Pass 2: started in the cycle right after done, with a stall.
      start_pass();
      run_pass(1);

      // Pass 3: random backpressure.
      start_pass();
      run_pass(2);

      // Reset around k~2000 with reads in flight.
      start_pass();
      guard = 0;
      while (n_acc < 2000 && guard < 10000) begin
         cyc(1'b1, 1'b0);
         guard++;
      end
      check("pre_reset_progress", (n_acc >= 2000), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      sb.delete(); iss_k = 0; n_acc = 0; done_cnt = 0;
      @(negedge clk);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      rst_n = 1'b1;
      repeat (4) cyc(1'b1, 1'b0);
      start_pass();
      run_pass(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule
